// File: rtl/rv_pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_pipe_ctrl_pkg
// Purpose : Shared types and constants for the RV32 pipeline scheduler.
//           Provides the scheduler FSM state encoding, the register
//           address width and the default scoreboard counter width.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package rv_pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PEND_W     = 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    BR_WAIT = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rv_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : rv_scoreboard
// Purpose : Per-register pending-write counters. A counter counts the
//           in-flight writers (S3..S5) of its register. x0 is never tracked.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           i_inc_en/i_inc_rd - writer issued into S3 for register i_inc_rd
//           i_dec_en/i_dec_rd - writer retired from S5 for register i_dec_rd
//           i_rs1/i_rs2     - lookup addresses
//           o_rs1_pend/o_rs2_pend - combinational pending counts
// Rev     : 1.0 - initial release
// ============================================================================
module rv_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc_en,
  input  logic [4:0]        i_inc_rd,
  input  logic              i_dec_en,
  input  logic [4:0]        i_dec_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  output logic [PEND_W-1:0] o_rs1_pend,
  output logic [PEND_W-1:0] o_rs2_pend
);

  import rv_pipe_ctrl_pkg::*;

  logic [PEND_W-1:0] w_pend [NUM_REGS];

  // x0 reads as never pending so a hardwired-zero source can never stall.
  assign w_pend[0] = '0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    logic              w_inc;
    logic              w_dec;
    logic [PEND_W-1:0] r_cnt;

    assign w_inc = i_inc_en && (i_inc_rd == REG_ADDR_W'(gi));
    assign w_dec = i_dec_en && (i_dec_rd == REG_ADDR_W'(gi));

    // Simultaneous issue and retire of the same register cancel out.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        a_no_overflow: assert (!(w_inc && !w_dec && (r_cnt == {PEND_W{1'b1}})));
        a_no_underflow: assert (!(w_dec && !w_inc && (r_cnt == '0)));
      end
    end

    assign w_pend[gi] = r_cnt;
  end

  assign o_rs1_pend = w_pend[i_rs1];
  assign o_rs2_pend = w_pend[i_rs2];

endmodule
`default_nettype wire

// File: rtl/rv_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rv_pipe_ctrl
// Purpose : Pipeline scheduler for the 5-stage in-order RV32 core. Stalls
//           S2 on RAW hazards against the pending-write scoreboard and
//           freezes fetch from branch issue until the S4 redirect.
// Ports   : clk, rst            - clock, asynchronous active-high reset
//           i_dec_*             - S2 instruction description
//           i_br_resolve        - S4 control transfer, nextpc valid
//           i_wb_valid/i_wb_rd  - S5 register file write
//           o_pc_en, o_en_s1_s2, o_clr_s1_s2, o_clr_s2_s3 - pipeline controls
//           o_issue             - S2 instruction advances to S3
//           o_state             - FSM state (debug)
//           o_bubble_cnt        - cycles with a bubble injected into S3
// Rev     : 1.0 - initial release
// ============================================================================
module rv_pipe_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_dec_valid,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  input  logic        i_dec_rs1_used,
  input  logic        i_dec_rs2_used,
  input  logic [4:0]  i_dec_rd,
  input  logic        i_dec_reg_write,
  input  logic        i_dec_is_branch,
  input  logic        i_br_resolve,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  output logic        o_pc_en,
  output logic        o_en_s1_s2,
  output logic        o_clr_s1_s2,
  output logic        o_clr_s2_s3,
  output logic        o_issue,
  output logic [1:0]  o_state,
  output logic [31:0] o_bubble_cnt
);

  import rv_pipe_ctrl_pkg::*;

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [31:0]       r_bubble_cnt;
  logic [PEND_W-1:0] w_rs1_pend;
  logic [PEND_W-1:0] w_rs2_pend;
  logic              w_hazard;
  logic              w_pc_en;
  logic              w_en_s1_s2;
  logic              w_clr_s1_s2;
  logic              w_clr_s2_s3;
  logic              w_issue;

  rv_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .PEND_W   (PEND_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_inc_en   (w_issue && i_dec_reg_write),
    .i_inc_rd   (i_dec_rd),
    .i_dec_en   (i_wb_valid),
    .i_dec_rd   (i_wb_rd),
    .i_rs1      (i_dec_rs1),
    .i_rs2      (i_dec_rs2),
    .o_rs1_pend (w_rs1_pend),
    .o_rs2_pend (w_rs2_pend)
  );

  // No write-through in the register file: a source retiring this very
  // cycle still reads stale data, so any non-zero count is a hazard.
  assign w_hazard = i_dec_valid &&
                    ((i_dec_rs1_used && (i_dec_rs1 != '0) && (w_rs1_pend != '0)) ||
                     (i_dec_rs2_used && (i_dec_rs2 != '0) && (w_rs2_pend != '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_en     = 1'b0;
    w_en_s1_s2  = 1'b1;
    w_clr_s1_s2 = 1'b0;
    w_clr_s2_s3 = 1'b0;
    w_issue     = 1'b0;
    if (rst) begin
      w_state_nxt = RUN;
      w_en_s1_s2  = 1'b0;
      w_clr_s1_s2 = 1'b1;
      w_clr_s2_s3 = 1'b1;
    end else begin
      case (r_state)
        BR_WAIT: begin
          // Fetch stays frozen until S4 supplies the redirect target.
          w_pc_en     = i_br_resolve;
          w_en_s1_s2  = 1'b0;
          w_clr_s1_s2 = 1'b1;
          w_clr_s2_s3 = 1'b1;
          if (i_br_resolve) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          // RUN and STALL share behaviour; the unused encoding recovers here.
          if (w_hazard) begin
            w_en_s1_s2  = 1'b0;
            w_clr_s2_s3 = 1'b1;
            w_state_nxt = STALL;
          end else if (i_dec_valid && i_dec_is_branch) begin
            // Branch proceeds; the sequential fetch behind it is squashed.
            w_issue     = 1'b1;
            w_clr_s1_s2 = 1'b1;
            w_state_nxt = BR_WAIT;
          end else begin
            w_pc_en     = 1'b1;
            w_issue     = i_dec_valid;
            w_state_nxt = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_clr_s2_s3) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign o_pc_en      = w_pc_en;
  assign o_en_s1_s2   = w_en_s1_s2;
  assign o_clr_s1_s2  = w_clr_s1_s2;
  assign o_clr_s2_s3  = w_clr_s2_s3;
  assign o_issue      = w_issue;
  assign o_state      = r_state;
  assign o_bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv_pipe_ctrl
// Purpose : Self-checking bench for rv_pipe_ctrl. A reference model tracks
//           the instructions occupying S3/S4/S5 and derives hazards,
//           writebacks, branch redirects and expected controls from them.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_rv_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_valid = 1'b0;
  logic [4:0]  dec_rs1 = '0;
  logic [4:0]  dec_rs2 = '0;
  logic        dec_rs1_used = 1'b0;
  logic        dec_rs2_used = 1'b0;
  logic [4:0]  dec_rd = '0;
  logic        dec_reg_write = 1'b0;
  logic        dec_is_branch = 1'b0;
  logic        br_resolve = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        pc_en;
  logic        en_s1_s2;
  logic        clr_s1_s2;
  logic        clr_s2_s3;
  logic        issue;
  logic [1:0]  state;
  logic [31:0] bubble_cnt;

  always #5 clk = ~clk;

  rv_pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .i_dec_valid     (dec_valid),
    .i_dec_rs1       (dec_rs1),
    .i_dec_rs2       (dec_rs2),
    .i_dec_rs1_used  (dec_rs1_used),
    .i_dec_rs2_used  (dec_rs2_used),
    .i_dec_rd        (dec_rd),
    .i_dec_reg_write (dec_reg_write),
    .i_dec_is_branch (dec_is_branch),
    .i_br_resolve    (br_resolve),
    .i_wb_valid      (wb_valid),
    .i_wb_rd         (wb_rd),
    .o_pc_en         (pc_en),
    .o_en_s1_s2      (en_s1_s2),
    .o_clr_s1_s2     (clr_s1_s2),
    .o_clr_s2_s3     (clr_s2_s3),
    .o_issue         (issue),
    .o_state         (state),
    .o_bubble_cnt    (bubble_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: slot 0 = S3, 1 = S4, 2 = S5.
  logic        m_v  [3];
  logic        m_rw [3];
  logic        m_br [3];
  logic [4:0]  m_rd [3];
  logic        m_brwait;
  logic        m_stall;
  int unsigned m_bub;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy(input logic [4:0] r);
    logic b;
    b = 1'b0;
    if (r != 5'd0)
      for (int i = 0; i < 3; i++)
        if (m_v[i] && m_rw[i] && (m_rd[i] == r)) b = 1'b1;
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 1'b0; m_rw[i] = 1'b0; m_br[i] = 1'b0; m_rd[i] = '0;
    end
    m_brwait = 1'b0;
    m_stall  = 1'b0;
    m_bub    = 0;
  endtask

  // One clock of stimulus; writebacks and redirects come from the model pipe.
  task automatic cycle(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic br, input logic noise,
                       output logic obs_iss);
    logic hz, e_pc, e_en, e_c1, e_c2, e_iss;
    logic [1:0] e_st;
    @(negedge clk);
    dec_valid = v; dec_rs1 = rs1; dec_rs1_used = u1; dec_rs2 = rs2; dec_rs2_used = u2;
    dec_rd = rd; dec_reg_write = rw; dec_is_branch = br;
    wb_valid   = m_v[2] & m_rw[2];
    wb_rd      = m_rd[2];
    br_resolve = (m_v[1] & m_br[1]) | (noise & ~m_brwait);
    #1;
    hz = v & ((u1 & busy(rs1)) | (u2 & busy(rs2)));
    e_pc = 1'b0; e_en = 1'b1; e_c1 = 1'b0; e_c2 = 1'b0; e_iss = 1'b0;
    if (m_brwait) begin
      e_pc = br_resolve; e_en = 1'b0; e_c1 = 1'b1; e_c2 = 1'b1;
    end else if (hz) begin
      e_en = 1'b0; e_c2 = 1'b1;
    end else if (v & br) begin
      e_iss = 1'b1; e_c1 = 1'b1;
    end else begin
      e_pc = 1'b1; e_iss = v;
    end
    e_st = m_brwait ? 2'd2 : (m_stall ? 2'd1 : 2'd0);
    check("pc_en", 32'(pc_en), 32'(e_pc));
    check("en_s1_s2", 32'(en_s1_s2), 32'(e_en));
    check("clr_s1_s2", 32'(clr_s1_s2), 32'(e_c1));
    check("clr_s2_s3", 32'(clr_s2_s3), 32'(e_c2));
    check("issue", 32'(issue), 32'(e_iss));
    check("state", 32'(state), 32'(e_st));
    check("bubble_cnt", bubble_cnt, m_bub);
    obs_iss = issue;
    @(posedge clk);
    if (e_c2) m_bub++;
    if (m_brwait) begin
      m_brwait = ~br_resolve;
      m_stall  = 1'b0;
    end else begin
      m_brwait = ~hz & v & br;
      m_stall  = hz;
    end
    for (int i = 2; i > 0; i--) begin
      m_v[i] = m_v[i-1]; m_rw[i] = m_rw[i-1]; m_br[i] = m_br[i-1]; m_rd[i] = m_rd[i-1];
    end
    m_v[0] = e_iss; m_rw[0] = rw; m_br[0] = br; m_rd[0] = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs1_used = 1'b1; dec_is_branch = 1'b1;
    br_resolve = 1'b1; wb_valid = 1'b0;
    #1;
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_en_s1_s2", 32'(en_s1_s2), 32'd0);
    check("rst_clr_s1_s2", 32'(clr_s1_s2), 32'd1);
    check("rst_clr_s2_s3", 32'(clr_s2_s3), 32'd1);
    check("rst_issue", 32'(issue), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_bubble_cnt", bubble_cnt, 32'd0);
    model_clear();
    @(negedge clk);
    dec_valid = 1'b0; dec_rs1_used = 1'b0; dec_is_branch = 1'b0; br_resolve = 1'b0;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    logic d;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, d);
  endtask

  initial begin
    logic iss;
    logic got;
    model_clear();

    // Reset state
    do_reset();

    // RAW: producer rd=5, consumer rs1=5 stalls three cycles
    cycle(1, 0, 0, 0, 0, 5, 1, 0, 0, iss);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 5, 1, 0, 0, 6, 0, 0, 0, iss);
      check("raw_issue_step", 32'(iss), (k == 3) ? 32'd1 : 32'd0);
    end
    #1;
    check("raw_bubbles", bubble_cnt, 32'd3);

    // x0 never stalls; an unused rs2 never stalls
    cycle(1, 0, 0, 0, 0, 0, 1, 0, 0, iss);
    cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, iss);
    check("x0_no_stall", 32'(iss), 32'd1);
    cycle(1, 0, 0, 0, 0, 3, 1, 0, 0, iss);
    cycle(1, 0, 0, 3, 0, 0, 0, 0, 0, iss);
    check("rs2_unused_no_stall", 32'(iss), 32'd1);
    idle(3);

    // Branch: BR_WAIT for two cycles, redirect from S4
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, iss);
    check("br_issue", 32'(iss), 32'd1);
    idle(3);
    #1;
    check("br_back_to_run", 32'(state), 32'd0);

    // Simultaneous issue and retire of r7
    cycle(1, 0, 0, 0, 0, 7, 1, 0, 0, iss);
    idle(2);
    cycle(1, 0, 0, 0, 0, 7, 1, 0, 0, iss);
    cycle(1, 7, 1, 0, 0, 0, 0, 0, 0, iss);
    check("simul_stall", 32'(iss), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      cycle(1, 7, 1, 0, 0, 0, 0, 0, 0, iss);
      got = iss;
    end
    check("simul_eventual_issue", 32'(got), 32'd1);
    idle(3);

    // Three writers to r9 in flight
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 9, 1, 0, 0, iss);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      cycle(1, 0, 0, 9, 1, 0, 0, 0, 0, iss);
      got = iss;
    end
    check("b2b_eventual_issue", 32'(got), 32'd1);
    idle(3);
    cycle(1, 9, 1, 9, 1, 0, 0, 0, 0, iss);
    check("b2b_drained", 32'(iss), 32'd1);

    // Reset mid-stall with pend[5]=2
    cycle(1, 0, 0, 0, 0, 5, 1, 0, 0, iss);
    cycle(1, 0, 0, 0, 0, 5, 1, 0, 0, iss);
    cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, iss);
    do_reset();
    cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, iss);
    check("post_reset_no_stall", 32'(iss), 32'd1);

    // Reset mid-BR_WAIT
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, iss);
    idle(1);
    do_reset();
    idle(2);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 9) < 8),
              5'($urandom_range(0, 4)), 1'($urandom),
              5'($urandom_range(0, 4)), 1'($urandom),
              5'($urandom_range(0, 4)), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), iss);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
